// File: rtl/seq_mag_comp_pkg.sv
// Package comp_pkg: types and helpers shared by the sequential comparator
// family.
//   state_t   : FSM states of the digit-serial compare.
//   RES_*     : one-hot result encodings, packed as {lower, equal, greater}.
//   flip_sign : conditionally inverts an operand's sign bit. After the flip,
//               a two's-complement compare can be done as an unsigned one.
package comp_pkg;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [2:0] RES_LT = 3'b100;
   localparam logic [2:0] RES_EQ = 3'b010;
   localparam logic [2:0] RES_GT = 3'b001;

   // Inverting the MSB maps two's-complement order onto unsigned order.
   function automatic logic flip_sign(input logic msb, input logic signed_mode);
      return msb ^ signed_mode;
   endfunction

endpackage

// File: rtl/seq_mag_comp_if.sv
// seq_mag_comp_if: request/result bundle for seq_mag_comp.
//   start, signed_mode, in1, in2 : request (driven by master).
//   busy, done, lower, equal, greater : status/result (driven by slave).
interface seq_mag_comp_if #(
   parameter int unsigned WIDTH = 32
);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] in1;
   logic [WIDTH-1:0] in2;
   logic             busy;
   logic             done;
   logic             lower;
   logic             equal;
   logic             greater;

   modport master (
      output start, signed_mode, in1, in2,
      input  busy, done, lower, equal, greater
   );

   modport slave (
      input  start, signed_mode, in1, in2,
      output busy, done, lower, equal, greater
   );
endinterface

// File: rtl/seq_mag_comp_digit_cmp.sv
// digit_cmp: combinational magnitude compare of one DIGIT-bit digit.
//   a, b : digits to compare (unsigned).
//   lt, eq, gt : exactly one is set.
module digit_cmp #(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   output logic             lt,
   output logic             eq,
   output logic             gt
);
   always_comb begin
      lt = (a < b);
      eq = (a == b);
      gt = (a > b);
   end
endmodule

// File: rtl/seq_mag_comp.sv
// seq_mag_comp: multi-cycle magnitude comparator, MSB digit first, stopping
// at the first differing digit.
//   clk, rst : rising-edge clock, synchronous active-high reset.
//   bus      : seq_mag_comp_if slave port; start is accepted only when idle,
//              done pulses one cycle, lower/equal/greater hold until the
//              next accepted start or reset.
module seq_mag_comp
   import comp_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DIGIT = 4
) (
   input  logic          clk,
   input  logic          rst,
   seq_mag_comp_if.slave bus
);
   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, a_nxt;
   logic [WIDTH-1:0] b_sh, b_nxt;
   logic [IDXW-1:0]  idx, idx_nxt;
   logic [2:0]       res, res_nxt;
   logic             done, done_nxt;
   logic             d_lt, d_eq, d_gt;

   // The digit under test is always the top of the shift registers.
   digit_cmp #(.DIGIT(DIGIT)) u_digit (
      .a  (a_sh[WIDTH-1 -: DIGIT]),
      .b  (b_sh[WIDTH-1 -: DIGIT]),
      .lt (d_lt),
      .eq (d_eq),
      .gt (d_gt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         idx   <= '0;
         res   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         a_sh  <= a_nxt;
         b_sh  <= b_nxt;
         idx   <= idx_nxt;
         res   <= res_nxt;
         done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      a_nxt     = a_sh;
      b_nxt     = b_sh;
      idx_nxt   = idx;
      res_nxt   = res;
      done_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               a_nxt            = bus.in1;
               b_nxt            = bus.in2;
               a_nxt[WIDTH-1]   = flip_sign(bus.in1[WIDTH-1], bus.signed_mode);
               b_nxt[WIDTH-1]   = flip_sign(bus.in2[WIDTH-1], bus.signed_mode);
               res_nxt          = '0;
               idx_nxt          = IDXW'(NDIG - 1);
               state_nxt        = RUN;
            end
         end
         RUN: begin
            if (!d_eq) begin
               res_nxt   = d_lt ? RES_LT : RES_GT;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else if (idx == '0) begin
               res_nxt   = RES_EQ;
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               idx_nxt = idx - 1'b1;
               a_nxt   = a_sh << DIGIT;
               b_nxt   = b_sh << DIGIT;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // d_gt is implied by !d_lt && !d_eq; kept on the sub-module for reuse.
   logic unused_gt;
   assign unused_gt = d_gt;

   assign bus.busy    = (state == RUN);
   assign bus.done    = done;
   assign bus.lower   = res[2];
   assign bus.equal   = res[1];
   assign bus.greater = res[0];
endmodule
